// File: rtl/i2c_reg_seq_if.sv
// Request/response and i2c_master command bus bundle for the register sequencer.
// The slave modport is the sequencer's view; master is the environment's view
// (request source plus bit engine).
interface i2c_reg_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rnw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nak;
    logic       rsp_tmo;
    logic [1:0] i2c_cmd;
    logic [7:0] i2c_data_in;
    logic       i2c_ack_in;
    logic       i2c_stb;
    logic [7:0] i2c_data_out;
    logic       i2c_ack_out;
    logic       i2c_ready;

    modport slave (
        input  req_valid, req_rnw, req_dev, req_reg, req_wdata,
        input  i2c_data_out, i2c_ack_out, i2c_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_nak, rsp_tmo,
        output i2c_cmd, i2c_data_in, i2c_ack_in, i2c_stb
    );

    modport master (
        output req_valid, req_rnw, req_dev, req_reg, req_wdata,
        output i2c_data_out, i2c_ack_out, i2c_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_nak, rsp_tmo,
        input  i2c_cmd, i2c_data_in, i2c_ack_in, i2c_stb
    );
endinterface

// File: rtl/i2c_reg_seq.sv
// Single-byte register write/read sequencer driving the i2c_master cmd/stb port.
// Walks a fixed step list (START/addr/reg/data/STOP, or the repeated-START read
// form), aborts to STOP on a NAKed write, and aborts without STOP on watchdog expiry.
module i2c_reg_seq #(
    parameter int TIMEOUT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    i2c_reg_seq_if.slave  bus
);
    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT, S_DONE} state_t;

    state_t               state, state_n;
    logic [2:0]           step, step_n;
    logic                 rnw_q;
    logic [6:0]           dev_q;
    logic [7:0]           reg_q, wdata_q;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 nak_q, tmo_q, ready_q;
    logic [7:0]           rdata_q;

    logic                 accept, stb, wdog_clr, wdog_inc, set_nak, set_tmo, cap_rd;
    logic                 wdog_max, active;
    logic [1:0]           step_cmd;
    logic [7:0]           step_data;
    logic                 step_ack;
    logic [2:0]           stop_step;

    assign wdog_max = &wdog;
    assign active   = (state == S_ISSUE) || (state == S_HOLD) || (state == S_WAIT);

    // Decode the command for the current step from the latched request.
    always_comb begin
        step_cmd  = CMD_STOP;
        step_data = 8'h00;
        step_ack  = 1'b0;
        stop_step = rnw_q ? 3'd6 : 3'd4;
        if (rnw_q) begin
            case (step)
                3'd0: step_cmd = CMD_START;
                3'd1: begin step_cmd = CMD_WRITE; step_data = {dev_q, 1'b0}; end
                3'd2: begin step_cmd = CMD_WRITE; step_data = reg_q; end
                3'd3: step_cmd = CMD_START;
                3'd4: begin step_cmd = CMD_WRITE; step_data = {dev_q, 1'b1}; end
                3'd5: begin step_cmd = CMD_READ;  step_ack  = 1'b1; end
                default: step_cmd = CMD_STOP;
            endcase
        end else begin
            case (step)
                3'd0: step_cmd = CMD_START;
                3'd1: begin step_cmd = CMD_WRITE; step_data = {dev_q, 1'b0}; end
                3'd2: begin step_cmd = CMD_WRITE; step_data = reg_q; end
                3'd3: begin step_cmd = CMD_WRITE; step_data = wdata_q; end
                default: step_cmd = CMD_STOP;
            endcase
        end
    end

    // Next-state and strobe logic; watchdog expiry outranks a simultaneous ready.
    always_comb begin
        state_n  = state;
        step_n   = step;
        accept   = 1'b0;
        stb      = 1'b0;
        wdog_clr = 1'b0;
        wdog_inc = 1'b0;
        set_nak  = 1'b0;
        set_tmo  = 1'b0;
        cap_rd   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    accept   = 1'b1;
                    step_n   = 3'd0;
                    wdog_clr = 1'b1;
                    state_n  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wdog_max) begin
                    set_tmo = 1'b1;
                    state_n = S_DONE;
                end else begin
                    wdog_inc = 1'b1;
                    if (bus.i2c_ready) begin
                        stb     = 1'b1;
                        state_n = S_HOLD;
                    end
                end
            end
            // Core drops ready one cycle after stb, so ready is not looked at here.
            S_HOLD: state_n = S_WAIT;
            S_WAIT: begin
                if (wdog_max) begin
                    set_tmo = 1'b1;
                    state_n = S_DONE;
                end else begin
                    wdog_inc = 1'b1;
                    if (bus.i2c_ready) begin
                        cap_rd = (step_cmd == CMD_READ);
                        if (step_cmd == CMD_WRITE && bus.i2c_ack_out) begin
                            set_nak  = 1'b1;
                            step_n   = stop_step;
                            wdog_clr = 1'b1;
                            state_n  = S_ISSUE;
                        end else if (step_cmd == CMD_STOP) begin
                            state_n = S_DONE;
                        end else begin
                            step_n   = step + 3'd1;
                            wdog_clr = 1'b1;
                            state_n  = S_ISSUE;
                        end
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, step, watchdog and request-ready registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            step    <= 3'd0;
            wdog    <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            ready_q <= (state_n == S_IDLE);
            if (wdog_clr)      wdog <= '0;
            else if (wdog_inc) wdog <= wdog + 1'b1;
        end
    end

    // Request latch, status flags and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnw_q   <= 1'b0;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            nak_q   <= 1'b0;
            tmo_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            if (accept) begin
                rnw_q   <= bus.req_rnw;
                dev_q   <= bus.req_dev;
                reg_q   <= bus.req_reg;
                wdata_q <= bus.req_wdata;
                nak_q   <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                if (set_nak) nak_q <= 1'b1;
                if (set_tmo) tmo_q <= 1'b1;
            end
            if (cap_rd) rdata_q <= bus.i2c_data_out;
        end
    end

    // Command fields come straight from the step decode so they stay put from
    // ISSUE through WAIT; outside a transaction the bus idles at STOP.
    assign bus.i2c_cmd     = active ? step_cmd  : CMD_STOP;
    assign bus.i2c_data_in = active ? step_data : 8'h00;
    assign bus.i2c_ack_in  = active ? step_ack  : 1'b0;
    assign bus.i2c_stb     = stb;
    assign bus.req_ready   = ready_q;
    assign bus.rsp_valid   = (state == S_DONE);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_nak     = nak_q;
    assign bus.rsp_tmo     = tmo_q;
endmodule
